wishbone_board_mem: RTL and testbench



---
 rtl/wishbone_board_mem_if.sv | 22 ++
 rtl/wishbone_board_mem.sv | 134 +++++++++++++
 tb/tb_wishbone_board_mem.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/wishbone_board_mem_if.sv
// wishbone_if: Wishbone classic signal bundle shared by the board-memory ports.
// The slave modport is what wishbone_board_mem connects to; master is for drivers.
interface wishbone_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_m2s;
    logic [31:0] dat_s2m;
    logic        ack;
    logic        err;

    modport slave (
        input  cyc, stb, we, adr, dat_m2s,
        output dat_s2m, ack, err
    );

    modport master (
        output cyc, stb, we, adr, dat_m2s,
        input  dat_s2m, ack, err
    );
endinterface

// File: rtl/wishbone_board_mem.sv
// wishbone_board_mem: Minesweeper cell store, BOARD_SIZE x BOARD_SIZE words of
// DATA_WIDTH bits, behind two independent Wishbone classic slaves (write, read).
// Cell layout: [3:0] neighbour count, [4] mine, [5] revealed, [6] flagged.
// Optional build macro BOARD_MEM_ERR_EN: out-of-range accesses answer with err
// instead of ack (write dropped, read data 0 in either build).
module wishbone_board_mem #(
    parameter int BOARD_SIZE = 16,
    parameter int DATA_WIDTH = 8
) (
    input logic       clk,
    input logic       rst,
    wishbone_if.slave slave_wr,
    wishbone_if.slave slave_rd
);
    localparam int CW    = (BOARD_SIZE > 1) ? $clog2(BOARD_SIZE) : 1;
    localparam int CELLS = BOARD_SIZE * BOARD_SIZE;
    localparam int IW    = (CELLS > 1) ? $clog2(CELLS) : 1;

    // Row/column fields must fit the board and everything above them must be zero.
    function automatic logic f_in_range(input logic [31:0] adr);
        logic [31:0] row;
        logic [31:0] col;
        row = 32'(adr[2*CW-1:CW]);
        col = 32'(adr[CW-1:0]);
        return (row < 32'(BOARD_SIZE)) && (col < 32'(BOARD_SIZE)) &&
               ((adr >> (2 * CW)) == 32'd0);
    endfunction

    // Linear cell index = row * BOARD_SIZE + col.
    function automatic logic [IW-1:0] f_index(input logic [31:0] adr);
        return IW'(32'(adr[2*CW-1:CW]) * 32'(BOARD_SIZE) + 32'(adr[CW-1:0]));
    endfunction

    logic                  w_wr_busy;
    logic                  w_rd_busy;
    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic                  w_wr_in_range;
    logic                  w_rd_in_range;
    logic [IW-1:0]         w_wr_idx;
    logic [IW-1:0]         w_rd_idx;
    logic                  r_wr_ack;
    logic                  r_rd_ack;
    logic [31:0]           r_rd_dat;
    logic [DATA_WIDTH-1:0] r_mem [CELLS];

    assign w_wr_in_range = f_in_range(slave_wr.adr);
    assign w_rd_in_range = f_in_range(slave_rd.adr);
    assign w_wr_idx      = f_index(slave_wr.adr);
    assign w_rd_idx      = f_index(slave_rd.adr);

    // A port takes a new request only while it is not answering the previous one.
    assign w_wr_accept = slave_wr.cyc & slave_wr.stb & ~w_wr_busy;
    assign w_rd_accept = slave_rd.cyc & slave_rd.stb & ~w_rd_busy;

    // Cell storage: lands the accepted in-range write; we=0 requests change nothing.
    // NOTE: the array is built from flops with an explicit async clear loop; a RAM
    // macro could not be cleared by rst, so keep this out of inferred memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CELLS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_accept && slave_wr.we && w_wr_in_range) begin
            r_mem[w_wr_idx] <= slave_wr.dat_m2s[DATA_WIDTH-1:0];
        end
    end

    // Read data register: zero-extended cell on the response cycle, 0 otherwise.
    // A same-cycle write to the same cell is not yet visible, so the old value is returned.
    // NOTE: non-blocking assignments here are what make the read sample the pre-write cell.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_dat <= '0;
        end else if (w_rd_accept && w_rd_in_range) begin
            r_rd_dat <= 32'(r_mem[w_rd_idx]);
        end else begin
            r_rd_dat <= '0;
        end
    end

`ifdef BOARD_MEM_ERR_EN
    logic r_wr_err;
    logic r_rd_err;

    assign w_wr_busy = r_wr_ack | r_wr_err;
    assign w_rd_busy = r_rd_ack | r_rd_err;

    // One-cycle response: ack for in-range requests, err for out-of-range ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ack <= 1'b0;
            r_wr_err <= 1'b0;
            r_rd_ack <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            r_wr_ack <= w_wr_accept &  w_wr_in_range;
            r_wr_err <= w_wr_accept & ~w_wr_in_range;
            r_rd_ack <= w_rd_accept &  w_rd_in_range;
            r_rd_err <= w_rd_accept & ~w_rd_in_range;
        end
    end

    assign slave_wr.err = r_wr_err;
    assign slave_rd.err = r_rd_err;
`else
    assign w_wr_busy = r_wr_ack;
    assign w_rd_busy = r_rd_ack;

    // One-cycle ack for every accepted request, in range or not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ack <= 1'b0;
            r_rd_ack <= 1'b0;
        end else begin
            r_wr_ack <= w_wr_accept;
            r_rd_ack <= w_rd_accept;
        end
    end

    assign slave_wr.err = 1'b0;
    assign slave_rd.err = 1'b0;
`endif

    assign slave_wr.ack     = r_wr_ack;
    assign slave_wr.dat_s2m = '0;
    assign slave_rd.ack     = r_rd_ack;
    assign slave_rd.dat_s2m = r_rd_dat;

    // Inputs the ports deliberately ignore (read-port we/data, unstored upper write bits).
    logic w_unused;
    assign w_unused = &{1'b0, slave_rd.we, slave_rd.dat_m2s,
                        slave_wr.dat_m2s[31:DATA_WIDTH]};
endmodule

// File: tb/tb_wishbone_board_mem.sv
// tb_wishbone_board_mem: directed stimulus with a response scoreboard. Drivers push
// the expected response when they issue a request; a negedge monitor pops and
// compares whenever a port answers. Works with or without BOARD_MEM_ERR_EN.
module tb_wishbone_board_mem;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    wishbone_if wr_bus ();
    wishbone_if rd_bus ();

    wishbone_board_mem #(
        .BOARD_SIZE(16),
        .DATA_WIDTH(8)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .slave_wr(wr_bus),
        .slave_rd(rd_bus)
    );

`ifdef BOARD_MEM_ERR_EN
    localparam logic OOR_ERR = 1'b1;
`else
    localparam logic OOR_ERR = 1'b0;
`endif

    typedef struct {
        logic        is_err;
        logic [31:0] data;
    } rd_rsp_t;

    logic    wr_q [$];
    rd_rsp_t rd_q [$];
    int      checks = 0;
    int      errors = 0;
    logic    mon_wr_exp;
    rd_rsp_t mon_rd_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every response must match the oldest expectation for its port.
    always @(negedge clk) begin
        if (rst) begin
            if (wr_bus.ack || wr_bus.err) begin
                if (wr_q.size() == 0) begin
                    check("wr_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    mon_wr_exp = wr_q.pop_front();
                    check("wr_err_flag", 32'(wr_bus.err), 32'(mon_wr_exp));
                    check("wr_ack_flag", 32'(wr_bus.ack), 32'(!mon_wr_exp));
                end
            end
            if (rd_bus.ack || rd_bus.err) begin
                if (rd_q.size() == 0) begin
                    check("rd_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    mon_rd_exp = rd_q.pop_front();
                    check("rd_err_flag", 32'(rd_bus.err), 32'(mon_rd_exp.is_err));
                    check("rd_ack_flag", 32'(rd_bus.ack), 32'(!mon_rd_exp.is_err));
                    check("rd_data", rd_bus.dat_s2m, mon_rd_exp.data);
                end
            end else begin
                check("rd_idle_data", rd_bus.dat_s2m, 32'd0);
            end
        end
    end

    // All drivers are entered and left on a falling edge.
    task automatic wr(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                      input logic exp_err);
        int n;
        if (wr_bus.ack || wr_bus.err) @(negedge clk);
        wr_bus.cyc = 1'b1; wr_bus.stb = 1'b1; wr_bus.we = we;
        wr_bus.adr = adr;  wr_bus.dat_m2s = dat;
        wr_q.push_back(exp_err);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(wr_bus.ack || wr_bus.err) && n < 8);
        check("wr_latency", 32'(n), 32'd1);
        wr_bus.cyc = 1'b0; wr_bus.stb = 1'b0; wr_bus.we = 1'b0;
    endtask

    task automatic rd(input logic [31:0] adr, input logic [31:0] exp_data,
                      input logic exp_err);
        int n;
        rd_rsp_t r;
        if (rd_bus.ack || rd_bus.err) @(negedge clk);
        rd_bus.cyc = 1'b1; rd_bus.stb = 1'b1; rd_bus.we = 1'b0; rd_bus.adr = adr;
        r.is_err = exp_err;
        r.data   = exp_data;
        rd_q.push_back(r);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(rd_bus.ack || rd_bus.err) && n < 8);
        check("rd_latency", 32'(n), 32'd1);
        rd_bus.cyc = 1'b0; rd_bus.stb = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int      n;
        int      acks;
        rd_rsp_t r;

        wr_bus.cyc = 1'b0; wr_bus.stb = 1'b0; wr_bus.we = 1'b0;
        wr_bus.adr = '0;   wr_bus.dat_m2s = '0;
        rd_bus.cyc = 1'b0; rd_bus.stb = 1'b0; rd_bus.we = 1'b0;
        rd_bus.adr = '0;   rd_bus.dat_m2s = '0;
        rst = 1'b0;
        #1;
        check("rst_wr_ack", 32'(wr_bus.ack), 32'd0);
        check("rst_wr_err", 32'(wr_bus.err), 32'd0);
        check("rst_rd_ack", 32'(rd_bus.ack), 32'd0);
        check("rst_rd_err", 32'(rd_bus.err), 32'd0);
        check("rst_rd_dat", rd_bus.dat_s2m, 32'd0);
        #19;
        rst = 1'b1;
        @(negedge clk);

        // Every cell reads back 0 after reset.
        for (int i = 0; i < 256; i++) begin
            rd(32'(i), 32'd0, 1'b0);
        end

        // Basic write/read, neighbour untouched; read on the cycle after write ack.
        wr(32'h35, 32'h13, 1'b1, 1'b0);
        rd(32'h35, 32'h13, 1'b0);
        rd(32'h36, 32'h00, 1'b0);

        // Upper data bits are discarded.
        wr(32'hFF, 32'hFFFF_FFA5, 1'b1, 1'b0);
        rd(32'hFF, 32'hA5, 1'b0);

        // we=0 on the write port is acknowledged and does nothing.
        wr(32'h36, 32'h44, 1'b0, 1'b0);
        rd(32'h36, 32'h00, 1'b0);

        // Same-cell collision: read sees the pre-write value, write still lands.
        wr(32'h10, 32'h01, 1'b1, 1'b0);
        @(negedge clk);
        wr_bus.cyc = 1'b1; wr_bus.stb = 1'b1; wr_bus.we = 1'b1;
        wr_bus.adr = 32'h10; wr_bus.dat_m2s = 32'h02;
        rd_bus.cyc = 1'b1; rd_bus.stb = 1'b1; rd_bus.adr = 32'h10;
        wr_q.push_back(1'b0);
        r.is_err = 1'b0;
        r.data   = 32'h01;
        rd_q.push_back(r);
        @(negedge clk);
        check("coll_wr_ack", 32'(wr_bus.ack), 32'd1);
        check("coll_rd_ack", 32'(rd_bus.ack), 32'd1);
        wr_bus.cyc = 1'b0; wr_bus.stb = 1'b0; wr_bus.we = 1'b0;
        rd_bus.cyc = 1'b0; rd_bus.stb = 1'b0;
        rd(32'h10, 32'h02, 1'b0);

        // Out of range: write dropped (cell 0 would alias if upper bits were ignored).
        wr(32'h100, 32'h5A, 1'b1, OOR_ERR);
        rd(32'h100, 32'h00, OOR_ERR);
        rd(32'h1035, 32'h00, OOR_ERR);
        rd(32'h00, 32'h00, 1'b0);
        rd(32'h35, 32'h13, 1'b0);
        rd(32'hFF, 32'hA5, 1'b0);

        // Held stb for 6 cycles yields exactly 3 read acks.
        if (rd_bus.ack || rd_bus.err) @(negedge clk);
        rd_bus.cyc = 1'b1; rd_bus.stb = 1'b1; rd_bus.adr = 32'h35;
        r.is_err = 1'b0;
        r.data   = 32'h13;
        for (int i = 0; i < 3; i++) rd_q.push_back(r);
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rd_bus.ack) acks++;
        end
        check("held_stb_acks", 32'(acks), 32'd3);
        rd_bus.cyc = 1'b0; rd_bus.stb = 1'b0;
        @(negedge clk);

        // Async reset during a write response: ack vanishes at once, cells clear.
        wr_bus.cyc = 1'b1; wr_bus.stb = 1'b1; wr_bus.we = 1'b1;
        wr_bus.adr = 32'h35; wr_bus.dat_m2s = 32'h77;
        @(posedge clk);
        #1;
        check("pre_rst_wr_ack", 32'(wr_bus.ack), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_wr_ack", 32'(wr_bus.ack), 32'd0);
        check("mid_rst_rd_dat", rd_bus.dat_s2m, 32'd0);
        wr_bus.cyc = 1'b0; wr_bus.stb = 1'b0; wr_bus.we = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rd(32'h35, 32'h00, 1'b0);
        rd(32'h10, 32'h00, 1'b0);
        rd(32'hFF, 32'h00, 1'b0);

        n = 0;
        while ((wr_q.size() != 0 || rd_q.size() != 0) && n < 4) begin
            @(negedge clk);
            n++;
        end
        check("wr_q_drained", 32'(wr_q.size()), 32'd0);
        check("rd_q_drained", 32'(rd_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
